// File: rtl/traffic_junction_controller.sv
// Highway/country-road junction controller with highway minimum green,
// country-green timeout and a latched pedestrian walk phase.
module traffic_junction_controller #(
  parameter int unsigned MIN_GREEN  = 8,
  parameter int unsigned Y2R_DELAY  = 3,
  parameter int unsigned R2G_DELAY  = 2,
  parameter int unsigned MAX_CGREEN = 10,
  parameter int unsigned WALK_TIME  = 5,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       x,
  input  logic       ped_req,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] phase
);

  localparam logic [2:0] S_HG  = 3'd0;
  localparam logic [2:0] S_HY  = 3'd1;
  localparam logic [2:0] S_AR1 = 3'd2;
  localparam logic [2:0] S_CG  = 3'd3;
  localparam logic [2:0] S_CY  = 3'd4;
  localparam logic [2:0] S_AR2 = 3'd5;
  localparam logic [2:0] S_PW  = 3'd6;

  localparam logic [1:0] L_RED = 2'd0;
  localparam logic [1:0] L_YEL = 2'd1;
  localparam logic [1:0] L_GRN = 2'd2;

  localparam logic [CNT_W-1:0] T_MING = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_Y2R  = CNT_W'(Y2R_DELAY - 1);
  localparam logic [CNT_W-1:0] T_R2G  = CNT_W'(R2G_DELAY - 1);
  localparam logic [CNT_W-1:0] T_MAXC = CNT_W'(MAX_CGREEN - 1);
  localparam logic [CNT_W-1:0] T_WALK = CNT_W'(WALK_TIME - 1);
  localparam logic [CNT_W-1:0] T_SAT  = {CNT_W{1'b1}};

  logic [2:0]       state, state_next;
  logic [CNT_W-1:0] timer, timer_next;
  logic             ped_pending, ped_next;
  logic [1:0]       hwy_next, cntry_next;
  logic             walk_next;

  // State register; outputs are registered decodes of the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_HG;
      timer       <= '0;
      ped_pending <= 1'b0;
      hwy         <= L_GRN;
      cntry       <= L_RED;
      walk        <= 1'b0;
      ped_wait    <= 1'b0;
      phase       <= S_HG;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      ped_pending <= ped_next;
      hwy         <= hwy_next;
      cntry       <= cntry_next;
      walk        <= walk_next;
      ped_wait    <= ped_next;
      phase       <= state_next;
    end
  end

  // Next-state, timer, pedestrian latch and output decode
  always_comb begin
    state_next = state;
    case (state)
      S_HG:  if (timer >= T_MING && (x || ped_pending)) state_next = S_HY;
      S_HY:  if (timer == T_Y2R) state_next = S_AR1;
      S_AR1: if (timer == T_R2G) state_next = ped_pending ? S_PW : S_CG;
      S_CG:  if (!x || timer == T_MAXC) state_next = S_CY;
      S_CY:  if (timer == T_Y2R) state_next = S_AR2;
      S_AR2: if (timer == T_R2G) state_next = S_HG;
      S_PW:  if (timer == T_WALK) state_next = x ? S_CG : S_AR2;
      default: state_next = S_HG;
    endcase

    if (state_next != state) timer_next = '0;
    else if (timer == T_SAT) timer_next = timer;
    else                     timer_next = timer + CNT_W'(1);

    // Entering the walk phase serves the request, overriding a same-edge press
    if (state_next == S_PW && state != S_PW) ped_next = 1'b0;
    else if (ped_req)                        ped_next = 1'b1;
    else                                     ped_next = ped_pending;

    hwy_next   = L_RED;
    cntry_next = L_RED;
    walk_next  = 1'b0;
    case (state_next)
      S_HG:    hwy_next   = L_GRN;
      S_HY:    hwy_next   = L_YEL;
      S_CG:    cntry_next = L_GRN;
      S_CY:    cntry_next = L_YEL;
      S_PW:    walk_next  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_junction_controller.sv
// Segment-table bench for traffic_junction_controller: each segment holds
// inputs constant over a cycle range and states the expected phase/ped_wait.
module tb_traffic_junction_controller;

  typedef struct {
    int         sc;
    int         first;
    int         last;
    logic       x;
    logic       ped;
    logic [2:0] ph;
    logic       pw;
  } seg_t;

  typedef struct {
    int         sc;
    int         cyc;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       walk;
    logic       pw;
    logic [2:0] ph;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       x = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] hwy, cntry;
  logic       walk, ped_wait;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  seg_t segs[$];
  exp_t sb[$];

  traffic_junction_controller dut (
    .clk(clk), .reset_n(reset_n), .x(x), .ped_req(ped_req),
    .hwy(hwy), .cntry(cntry), .walk(walk), .ped_wait(ped_wait), .phase(phase)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  function automatic exp_t expect_of(int sc, int cyc, logic [2:0] ph, logic pw);
    exp_t e;
    e.sc = sc; e.cyc = cyc; e.ph = ph; e.pw = pw;
    e.hwy = 2'd0; e.cntry = 2'd0; e.walk = 1'b0;
    case (ph)
      3'd0: e.hwy = 2'd2;
      3'd1: e.hwy = 2'd1;
      3'd3: e.cntry = 2'd2;
      3'd4: e.cntry = 2'd1;
      3'd6: e.walk = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(string name, int sc, int cyc, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL sc%0d cyc%0d %s got %0d want %0d", sc, cyc, name, got, want);
    end
  endtask

  task automatic add(int sc, int f, int l, logic xi, logic pi, logic [2:0] ph, logic pw);
    seg_t s;
    s.sc = sc; s.first = f; s.last = l; s.x = xi; s.ped = pi; s.ph = ph; s.pw = pw;
    segs.push_back(s);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; x = 1'b0; ped_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drives one scenario from the segment table; called at a negedge
  task automatic run_sc(int sc);
    exp_t e;
    do_reset();
    foreach (segs[i]) begin
      if (segs[i].sc == sc) begin
        for (int c = segs[i].first; c <= segs[i].last; c++) begin
          x = segs[i].x;
          ped_req = segs[i].ped;
          sb.push_back(expect_of(sc, c, segs[i].ph, segs[i].pw));
          #1;
          e = sb.pop_front();
          chk("phase", e.sc, e.cyc, int'(phase), int'(e.ph));
          chk("hwy", e.sc, e.cyc, int'(hwy), int'(e.hwy));
          chk("cntry", e.sc, e.cyc, int'(cntry), int'(e.cntry));
          chk("walk", e.sc, e.cyc, int'(walk), int'(e.walk));
          chk("ped_wait", e.sc, e.cyc, int'(ped_wait), int'(e.pw));
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    // 1: car held from reset, country green times out
    add(1, 0, 7, 1, 0, 0, 0);   add(1, 8, 10, 1, 0, 1, 0);
    add(1, 11, 12, 1, 0, 2, 0); add(1, 13, 22, 1, 0, 3, 0);
    add(1, 23, 25, 1, 0, 4, 0); add(1, 26, 27, 1, 0, 5, 0);
    add(1, 28, 30, 1, 0, 0, 0);
    // 2: idle junction stays highway green
    add(2, 0, 199, 0, 0, 0, 0);
    // 3: car leaves after 3 green cycles
    add(3, 0, 7, 1, 0, 0, 0);   add(3, 8, 10, 1, 0, 1, 0);
    add(3, 11, 12, 1, 0, 2, 0); add(3, 13, 15, 1, 0, 3, 0);
    add(3, 16, 16, 0, 0, 3, 0); add(3, 17, 19, 0, 0, 4, 0);
    add(3, 20, 21, 0, 0, 5, 0); add(3, 22, 24, 0, 0, 0, 0);
    // 4: single pedestrian pulse, no car
    add(4, 0, 1, 0, 0, 0, 0);   add(4, 2, 2, 0, 1, 0, 0);
    add(4, 3, 7, 0, 0, 0, 1);   add(4, 8, 10, 0, 0, 1, 1);
    add(4, 11, 12, 0, 0, 2, 1); add(4, 13, 17, 0, 0, 6, 0);
    add(4, 18, 19, 0, 0, 5, 0); add(4, 20, 22, 0, 0, 0, 0);
    // 5: car and pedestrian together, second press during the walk
    add(5, 0, 0, 1, 1, 0, 0);   add(5, 1, 7, 1, 0, 0, 1);
    add(5, 8, 10, 1, 0, 1, 1);  add(5, 11, 12, 1, 0, 2, 1);
    add(5, 13, 14, 1, 0, 6, 0); add(5, 15, 15, 1, 1, 6, 0);
    add(5, 16, 17, 1, 0, 6, 1); add(5, 18, 27, 1, 0, 3, 1);
    add(5, 28, 30, 1, 0, 4, 1); add(5, 31, 32, 1, 0, 5, 1);
    add(5, 33, 40, 1, 0, 0, 1); add(5, 41, 43, 1, 0, 1, 1);
    add(5, 44, 45, 1, 0, 2, 1); add(5, 46, 47, 1, 0, 6, 0);
    // 6: prefix into country green with a pending request
    add(6, 0, 7, 1, 0, 0, 0);   add(6, 8, 10, 1, 0, 1, 0);
    add(6, 11, 12, 1, 0, 2, 0); add(6, 13, 13, 1, 0, 3, 0);
    add(6, 14, 14, 1, 1, 3, 0); add(6, 15, 15, 1, 0, 3, 1);
    // 7: after reset, highway green holds the minimum
    add(7, 0, 7, 1, 0, 0, 0);   add(7, 8, 8, 1, 0, 1, 0);

    @(negedge clk);
    #1;
    chk("rst_phase", 0, 0, int'(phase), 0);
    chk("rst_hwy", 0, 0, int'(hwy), 2);
    for (int s = 1; s <= 6; s++) run_sc(s);

    // Asynchronous reset in the middle of a country-green cycle
    chk("pre_cntry", 6, 16, int'(cntry), 2);
    chk("pre_ped_wait", 6, 16, int'(ped_wait), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_hwy", 6, 16, int'(hwy), 2);
    chk("arst_cntry", 6, 16, int'(cntry), 0);
    chk("arst_walk", 6, 16, int'(walk), 0);
    chk("arst_ped_wait", 6, 16, int'(ped_wait), 0);
    chk("arst_phase", 6, 16, int'(phase), 0);
    @(negedge clk);
    run_sc(7);

    if (sb.size() != 0) chk("sb_empty", 0, 0, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
